// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: IF/IE registers, fixed-priority arbitration and ack/dispatch handshake
module interrupt_ctrl (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic [4:0] irq_src,
  input  logic       cpu_sel_if,
  input  logic       cpu_sel_ie,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  output logic       irq,
  input  logic       irq_ack,
  output logic [7:0] irq_vector,
  output logic       dispatch_busy
);
  typedef enum logic {IDLE, DISPATCHED} state_t;
  state_t     state;
  logic [4:0] if_r, pend, ack_clr, if_base;
  logic [7:0] ie_r;
  logic [2:0] win;
  logic       wr_if, wr_ie;
  assign wr_if   = cpu_sel_if && cpu_wr;
  assign wr_ie   = cpu_sel_ie && cpu_wr;
  assign pend    = if_r & ie_r[4:0];
  assign win     = pend[0] ? 3'd0 : pend[1] ? 3'd1 : pend[2] ? 3'd2 : pend[3] ? 3'd3 : 3'd4;
  assign ack_clr = (irq_ack && |pend) ? 5'(1) << win : 5'd0;
  assign if_base = wr_if ? cpu_di[4:0] : if_r;
  assign irq     = |pend;
  assign cpu_do  = cpu_sel_if ? {3'b111, if_r} : cpu_sel_ie ? ie_r : 8'hFF;
  assign dispatch_busy = (state == DISPATCHED);
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      if_r       <= '0;
      ie_r       <= '0;
      irq_vector <= '0;
      state      <= IDLE;
    end else if (ce) begin
      // source pulses are OR-ed last so they beat both writes and ack clears
      if_r <= (if_base & ~ack_clr) | irq_src;
      if (wr_ie) ie_r <= cpu_di;
      if (irq_ack) begin
        irq_vector <= |pend ? {2'b01, win, 3'b000} : 8'h00;
        state      <= DISPATCHED;
      end else if (wr_if || wr_ie) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Gameboy interrupt controller: owns the IF (0xFF0F) and IE (0xFFFF) registers, latches interrupt request pulses from VBlank, STAT, timer, serial and joypad sources, and arbitrates them by fixed priority for the CPU. It sits between the peripheral `irq` outputs (including the timer's one-tick `irq` pulse) and the CPU core's interrupt input. It also runs the acknowledge/dispatch handshake, supplying the vector and clearing the serviced IF bit.

## Interface
Parameters:
- none

Ports:
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  4 MHz CPU clock enable; all register state advances only when `ce`=1.
- `irq_src`  in  5  request pulses. Bit 0 VBlank, 1 STAT, 2 timer, 3 serial, 4 joypad. Each is sampled on `ce` cycles, and any cycle with a bit high is one request.
- `cpu_sel_if`  in  1  CPU bus select for IF.
- `cpu_sel_ie`  in  1  CPU bus select for IE.
- `cpu_wr`  in  1  write strobe, qualified by the selects.
- `cpu_di`  in  8  write data.
- `cpu_do`  out  8  read data. `{3'b111, if_r}` when `cpu_sel_if`, `ie_r` when `cpu_sel_ie`, otherwise 8'hFF.
- `irq`  out  1  pending level to CPU: `|(if_r & ie_r[4:0])`. The CPU applies IME itself; `irq` also serves as HALT wake.
- `irq_ack`  in  1  CPU dispatch strobe, a single `ce` cycle issued after the PC high-byte push.
- `irq_vector`  out  8  vector of the last dispatch, 8'h40/48/50/58/60, or 8'h00 if cancelled.
- `dispatch_busy`  out  1  high from `irq_ack` until the CPU's next `irq_ack` or `cpu_wr` to IF/IE. Debug and verification visibility only.

## Operation
- Registers: `if_r[4:0]`, `ie_r[7:0]`, `irq_vector[7:0]`, state `{IDLE, DISPATCHED}`.
- Reset values: `if_r`=0, `ie_r`=0, `irq_vector`=8'h00, state IDLE. Therefore `irq`=0, `dispatch_busy`=0, and `cpu_do` idle is 8'hFF.
- IF next value on a `ce` cycle: `base | irq_src`, then with `ack_clr` applied as `& ~ack_clr`, except that bits set by `irq_src` this cycle survive the clear.
  - `base` = `cpu_di[4:0]` if IF is written this cycle, else `if_r`.
  - `ack_clr` = one-hot of the serviced bit, or 0.
  - Net effect: a source pulse always wins over both a CPU write and an ack clear on the same bit.
- IE write: `ie_r <= cpu_di` on a `ce` cycle with `cpu_sel_ie && cpu_wr`. All 8 bits are stored. Only bits [4:0] gate `irq`.
- Priority: the lowest set bit of `if_r & ie_r[4:0]` wins. Vector = 8'h40 + 8×bit index.
- Arbitration on `irq_ack` (with `ce`) uses the register values *before* this edge, so an IE write landing on the same `ce` cycle is not yet visible. This models the push-to-IE cancel quirk.
  - If `pend = if_r & ie_r[4:0]` is nonzero: `irq_vector` <= vector of the winning bit, that IF bit is cleared, state becomes DISPATCHED.
  - If `pend` = 0 (request withdrawn by an earlier IE/IF write during dispatch): `irq_vector` <= 8'h00, no IF bit is cleared, state becomes DISPATCHED.
- DISPATCHED → IDLE: on the next `ce` cycle with `irq_ack`=0 and any CPU write to IF or IE, or on the next `irq_ack`, which re-arbitrates and stays in DISPATCHED.
- `irq_vector` holds its value until the next `irq_ack`. It is never cleared except by reset.
- `irq_src` pulses that arrive while `ce`=0 are not captured. Sources must hold their pulse through a `ce` cycle, as the timer does.
- Save states: none in this block. State is reconstructible from an IF/IE write-back by the save-state loader through the CPU port.

## Timing
- Source pulse on `ce` cycle N: `if_r` bit set after edge N. `irq` rises in the clock following edge N, as combinational logic on registers, provided the IE bit is set.
- CPU write to IF or IE on `ce` cycle N: visible on `cpu_do` and `irq` after edge N.
- `irq_ack` on `ce` cycle N: `irq_vector` and the cleared IF bit are valid after edge N. `irq` drops in the same clock if no other enabled bit is pending.
- Reads are combinational from registers: zero-latency `cpu_do`, with no side effects.
- Reset asserted mid-dispatch: all state returns to reset values on the next `clk_sys` edge, regardless of `ce`.
- Simultaneous pulses on all five sources: all five IF bits are set; successive acks yield 40, 48, 50, 58, 60 in that order.

## Test plan
- Reset, then IE=8'h04 and a timer pulse on bit 2 → `irq`=1, IF read 8'hE4. `irq_ack` → `irq_vector`=8'h50, IF read 8'hE0, `irq`=0.
- IE=8'h1F and `irq_src`=5'b11111 in one `ce` cycle → five acks give 8'h40, 48, 50, 58, 60 in order, then `irq`=0.
- IF=8'h04 and IE=8'h04, then IE written to 8'h00 before `irq_ack` → `irq_vector`=8'h00 and IF remains 8'hE4.
- CPU writes IF=8'h00 on the same `ce` cycle as a timer pulse → IF reads 8'hE4.
- `irq_ack` clearing bit 0 on the same cycle as a new VBlank pulse → bit 0 stays set, `irq_vector`=8'h40, `irq` remains 1.
- Timer pulse held only while `ce`=0 → IF unchanged at 8'hE0. Reset during DISPATCHED → `irq_vector`=8'h00, `dispatch_busy`=0.
